// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
//   DIV_DIVIDEND_W : dividend / quotient width
//   DIV_DIVISOR_W  : divisor / remainder width
//   DIV_CNT_W      : iteration counter width
//   div_state_t    : controller state encoding
package div_pkg;

  localparam int DIV_DIVIDEND_W = 16;
  localparam int DIV_DIVISOR_W  = 8;
  localparam int DIV_CNT_W      = $clog2(DIV_DIVIDEND_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational.
//   partial_in  : current partial remainder (DIVISOR_W+1 bits, MSB is the guard bit)
//   bit_in      : next dividend bit, shifted into the partial remainder
//   divisor     : divisor
//   partial_out : partial remainder after the trial subtraction
//   q_bit       : quotient bit produced by this iteration
module div_step
  import div_pkg::*;
#(
  parameter int DIVISOR_W = DIV_DIVISOR_W
) (
  input  logic [DIVISOR_W:0]   partial_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   partial_out,
  output logic                 q_bit
);

  logic [DIVISOR_W:0] p;
  logic [DIVISOR_W:0] d_ext;

  // The guard bit of the incoming partial is always zero after a step
  // (partial < divisor), so only the low bits feed the shift.
  logic unused_guard;
  assign unused_guard = partial_in[DIVISOR_W];

  assign p     = {partial_in[DIVISOR_W-1:0], bit_in};
  assign d_ext = {1'b0, divisor};

  always_comb begin
    q_bit       = 1'b0;
    partial_out = p;
    if (p >= d_ext) begin
      q_bit       = 1'b1;
      partial_out = p - d_ext;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with valid/ready handshakes.
//   clk         : clock, rising edge
//   reset_n     : asynchronous active-low reset
//   in_valid    : operands present
//   in_ready    : divider can accept operands (IDLE only)
//   dividend    : unsigned dividend
//   divisor     : unsigned divisor
//   out_valid   : result present (DONE)
//   out_ready   : consumer takes the result
//   quotient    : floor(dividend / divisor), all ones on divide by zero
//   remainder   : dividend mod divisor, zero on divide by zero
//   div_by_zero : result came from a zero divisor
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for operands, in_ready high
// BUSY  | one restoring iteration per cycle, DIVIDEND_W cycles total
// DONE  | result held until out_valid && out_ready
module seq_divider
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DIV_DIVIDEND_W,
  parameter int DIVISOR_W  = DIV_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;

  div_state_t            state;
  logic [DIVIDEND_W-1:0] dividend_sr;
  logic [DIVIDEND_W-1:0] quot_sr;
  logic [DIVISOR_W-1:0]  divisor_q;
  logic [DIVISOR_W:0]    partial;
  logic [CNT_W-1:0]      cnt;

  logic [DIVISOR_W:0]    step_partial;
  logic                  step_q_bit;

  div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .partial_in  (partial),
    .bit_in      (dividend_sr[DIVIDEND_W-1]),
    .divisor     (divisor_q),
    .partial_out (step_partial),
    .q_bit       (step_q_bit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      dividend_sr <= '0;
      quot_sr     <= '0;
      divisor_q   <= '0;
      partial     <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            dividend_sr <= dividend;
            divisor_q   <= divisor;
            quot_sr     <= '0;
            partial     <= '0;
            cnt         <= CNT_W'(DIVIDEND_W - 1);
            in_ready    <= 1'b0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end else begin
              state <= BUSY;
            end
          end
        end

        BUSY: begin
          partial     <= step_partial;
          quot_sr     <= {quot_sr[DIVIDEND_W-2:0], step_q_bit};
          dividend_sr <= {dividend_sr[DIVIDEND_W-2:0], 1'b0};
          if (cnt == '0) begin
            quotient    <= {quot_sr[DIVIDEND_W-2:0], step_q_bit};
            remainder   <= step_partial[DIVISOR_W-1:0];
            div_by_zero <= 1'b0;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        DONE: begin
          // A divide by zero enters DONE straight from IDLE with out_valid
          // still low; raising it here gives that path its one-cycle latency.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int checks;
  int failures;

  seq_divider dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Present operands and wait (bounded) for the accepting edge.
  task automatic start_op(input logic [15:0] a, input logic [7:0] b, input string name);
    int n;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check({name, "_accept_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
  endtask

  // Cycles from the accepting edge until out_valid is seen.
  task automatic wait_done(output int lat, input string name);
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    check({name, "_done_seen"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    int lat;
    int seen;
    checks   = 0;
    failures = 0;

    vecs[0] = '{16'd1000,  8'd7,   16'd142,   8'd6,   1'b0, 16};
    vecs[1] = '{16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0, 16};
    vecs[2] = '{16'd65535, 8'd255, 16'd257,   8'd0,   1'b0, 16};
    vecs[3] = '{16'd5,     8'd200, 16'd0,     8'd5,   1'b0, 16};
    vecs[4] = '{16'd1234,  8'd0,   16'hFFFF,  8'd0,   1'b1, 1};
    vecs[5] = '{16'd40000, 8'd3,   16'd13333, 8'd1,   1'b0, 16};
    vecs[6] = '{16'd12345, 8'd123, 16'd100,   8'd45,  1'b0, 16};
    vecs[7] = '{16'd256,   8'd255, 16'd1,     8'd1,   1'b0, 16};
    vecs[8] = '{16'd0,     8'd5,   16'd0,     8'd0,   1'b0, 16};
    vecs[9] = '{16'd255,   8'd16,  16'd15,    8'd15,  1'b0, 16};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;

    // Reset then idle
    repeat (3) step();
    reset_n = 1'b1;
    step();
    check("rst_in_ready",    32'(in_ready),    32'd1);
    check("rst_out_valid",   32'(out_valid),   32'd0);
    check("rst_quotient",    32'(quotient),    32'd0);
    check("rst_remainder",   32'(remainder),   32'd0);
    check("rst_div_by_zero", 32'(div_by_zero), 32'd0);

    // Table-driven vectors, out_ready held high
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      string nm;
      nm = $sformatf("v%0d_%0d_by_%0d", i, vecs[i].a, vecs[i].b);
      start_op(vecs[i].a, vecs[i].b, nm);
      check({nm, "_in_ready_low"}, 32'(in_ready), 32'd0);
      wait_done(lat, nm);
      check({nm, "_latency"},   32'(lat),         32'(vecs[i].lat));
      check({nm, "_quotient"},  32'(quotient),    32'(vecs[i].q));
      check({nm, "_remainder"}, 32'(remainder),   32'(vecs[i].r));
      check({nm, "_dbz"},       32'(div_by_zero), 32'(vecs[i].dbz));
      step();
      check({nm, "_valid_drop"}, 32'(out_valid), 32'd0);
      check({nm, "_ready_back"}, 32'(in_ready),  32'd1);
    end

    // Back-to-back throughput with out_ready high: 18 cycles per division
    start_op(16'd100, 8'd10, "tput_a");
    wait_done(lat, "tput_a");
    step();
    dividend = 16'd100;
    divisor  = 16'd10 == 0 ? 8'd0 : 8'd9;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("tput_second_accepted", 32'(in_ready), 32'd0);
    wait_done(lat, "tput_b");
    check("tput_b_quotient",  32'(quotient),  32'd11);
    check("tput_b_remainder", 32'(remainder), 32'd1);
    step();

    // Backpressure: result held 10 cycles, new operands ignored
    out_ready = 1'b0;
    start_op(16'd1000, 8'd7, "bp");
    wait_done(lat, "bp");
    dividend = 16'd9;
    divisor  = 8'd3;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      check($sformatf("bp_hold%0d_valid", c),     32'(out_valid), 32'd1);
      check($sformatf("bp_hold%0d_in_ready", c),  32'(in_ready),  32'd0);
      check($sformatf("bp_hold%0d_quotient", c),  32'(quotient),  32'd142);
      check($sformatf("bp_hold%0d_remainder", c), 32'(remainder), 32'd6);
    end
    out_ready = 1'b1;
    step();
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_ready", 32'(in_ready),  32'd1);
    step();
    in_valid = 1'b0;
    check("bp_next_accepted", 32'(in_ready), 32'd0);
    wait_done(lat, "bp_next");
    check("bp_next_latency",   32'(lat),       32'd16);
    check("bp_next_quotient",  32'(quotient),  32'd3);
    check("bp_next_remainder", 32'(remainder), 32'd0);
    step();

    // Divide by zero with the consumer stalled: result and flag held
    out_ready = 1'b0;
    start_op(16'd777, 8'd0, "dbz_hold");
    wait_done(lat, "dbz_hold");
    check("dbz_hold_latency", 32'(lat), 32'd1);
    repeat (3) step();
    check("dbz_hold_valid",    32'(out_valid),   32'd1);
    check("dbz_hold_flag",     32'(div_by_zero), 32'd1);
    check("dbz_hold_quotient", 32'(quotient),    32'hFFFF);
    out_ready = 1'b1;
    step();
    check("dbz_hold_release", 32'(out_valid), 32'd0);

    // Reset at iteration 8 discards the operation
    start_op(16'd40000, 8'd3, "rst_mid");
    repeat (7) step();
    reset_n = 1'b0;
    #1;
    check("rst_mid_valid_async", 32'(out_valid), 32'd0);
    check("rst_mid_ready_async", 32'(in_ready),  32'd1);
    repeat (2) step();
    check("rst_mid_quotient", 32'(quotient), 32'd0);
    reset_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (out_valid) seen++;
    end
    check("rst_mid_no_result", 32'(seen), 32'd0);
    start_op(16'd40000, 8'd3, "rst_after");
    wait_done(lat, "rst_after");
    check("rst_after_latency",   32'(lat),       32'd16);
    check("rst_after_quotient",  32'(quotient),  32'd13333);
    check("rst_after_remainder", 32'(remainder), 32'd1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
